id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I core. It captures decoded operands, register indices, immediate and control bits from decode and presents them to execute, where they feed the forwarding unit and ALU. It inserts a one-cycle bubble on a load-use dependency and raises a stall back to PC/IF-ID. It supports branch flush and downstream hold, and keeps a saturating count of inserted load-use bubbles.

---
 rtl/rv_pipe_pkg.sv | 18 +
 rtl/id_ex_stage_if.sv | 45 ++++
 rtl/hazard_detect.sv | 21 ++
 rtl/id_ex_stage.sv | 83 ++++++++
 tb/tb_id_ex_stage.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: control bundle width, control bit positions and the NOP bundle.
package rv_pipe_pkg;

  localparam int CTRL_W = 11;

  localparam int REG_WRITE  = 0;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 2;
  localparam int MEM_TO_REG = 3;
  localparam int ALU_SRC    = 4;
  localparam int BRANCH     = 5;
  localparam int JUMP       = 6;
  localparam int ALU_OP_LO  = 7;
  localparam int ALU_OP_HI  = 10;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode side inputs, registered EX outputs, hazard/stall and bubble counter.
interface id_ex_stage_if #(
  parameter int CTRL_W = rv_pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
);
  logic              flush_i;
  logic              stall_i;
  logic              id_valid_i;
  logic [31:0]       id_pc_i;
  logic [4:0]        id_rs1_i;
  logic [4:0]        id_rs2_i;
  logic [4:0]        id_rd_i;
  logic              id_uses_rs1_i;
  logic              id_uses_rs2_i;
  logic [31:0]       id_reg1_i;
  logic [31:0]       id_reg2_i;
  logic [31:0]       id_imm_i;
  logic [CTRL_W-1:0] id_ctrl_i;

  logic              ex_valid_o;
  logic [31:0]       ex_pc_o;
  logic [31:0]       ex_reg1_o;
  logic [31:0]       ex_reg2_o;
  logic [31:0]       ex_imm_o;
  logic [4:0]        ex_rs1_o;
  logic [4:0]        ex_rs2_o;
  logic [4:0]        ex_rd_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic              hazard_stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output flush_i, stall_i, id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i,
           id_uses_rs1_i, id_uses_rs2_i, id_reg1_i, id_reg2_i, id_imm_i, id_ctrl_i,
    input  ex_valid_o, ex_pc_o, ex_reg1_o, ex_reg2_o, ex_imm_o, ex_rs1_o, ex_rs2_o,
           ex_rd_o, ex_ctrl_o, hazard_stall_o, bubble_cnt_o
  );

  modport slave (
    input  flush_i, stall_i, id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i,
           id_uses_rs1_i, id_uses_rs2_i, id_reg1_i, id_reg2_i, id_imm_i, id_ctrl_i,
    output ex_valid_o, ex_pc_o, ex_reg1_o, ex_reg2_o, ex_imm_o, ex_rs1_o, ex_rs2_o,
           ex_rd_o, ex_ctrl_o, hazard_stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination is read by the real instruction in decode.
module hazard_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is never really written, so a load targeting it cannot create a dependency
  assign load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, downstream hold
// and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
  parameter int CTRL_W = rv_pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input logic           clk_i,
  input logic           reset_i,
  id_ex_stage_if.slave  bus
);
  localparam int MR = rv_pipe_pkg::MEM_READ;

  logic             load_use;
  logic             hold;
  logic             make_bubble;
  logic             count_bubble;
  logic [CNT_W-1:0] cnt;

  hazard_detect u_hazard (
    .id_valid    (bus.id_valid_i),
    .id_rs1      (bus.id_rs1_i),
    .id_rs2      (bus.id_rs2_i),
    .id_uses_rs1 (bus.id_uses_rs1_i),
    .id_uses_rs2 (bus.id_uses_rs2_i),
    .ex_valid    (bus.ex_valid_o),
    .ex_mem_read (bus.ex_ctrl_o[MR]),
    .ex_rd       (bus.ex_rd_o),
    .load_use    (load_use)
  );

  // Stall still reports the hazard: the load stays in EX, so decode must hold as well
  assign bus.hazard_stall_o = load_use && !bus.flush_i;

  assign hold         = bus.stall_i && !bus.flush_i;
  assign count_bubble = load_use && !bus.flush_i && !bus.stall_i;
  assign make_bubble  = bus.flush_i || load_use || !bus.id_valid_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bus.ex_valid_o <= 1'b0;
      bus.ex_pc_o    <= '0;
      bus.ex_reg1_o  <= '0;
      bus.ex_reg2_o  <= '0;
      bus.ex_imm_o   <= '0;
      bus.ex_rs1_o   <= '0;
      bus.ex_rs2_o   <= '0;
      bus.ex_rd_o    <= '0;
      bus.ex_ctrl_o  <= '0;
    end else if (!hold) begin
      if (make_bubble) begin
        bus.ex_valid_o <= 1'b0;
        bus.ex_pc_o    <= '0;
        bus.ex_reg1_o  <= '0;
        bus.ex_reg2_o  <= '0;
        bus.ex_imm_o   <= '0;
        bus.ex_rs1_o   <= '0;
        bus.ex_rs2_o   <= '0;
        bus.ex_rd_o    <= '0;
        bus.ex_ctrl_o  <= '0;
      end else begin
        bus.ex_valid_o <= 1'b1;
        bus.ex_pc_o    <= bus.id_pc_i;
        bus.ex_reg1_o  <= bus.id_reg1_i;
        bus.ex_reg2_o  <= bus.id_reg2_i;
        bus.ex_imm_o   <= bus.id_imm_i;
        bus.ex_rs1_o   <= bus.id_rs1_i;
        bus.ex_rs2_o   <= bus.id_rs2_i;
        bus.ex_rd_o    <= bus.id_rd_i;
        bus.ex_ctrl_o  <= bus.id_ctrl_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (count_bubble && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.bubble_cnt_o = cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; counter narrowed to 8 bits so saturation is reachable quickly.
module tb_id_ex_stage;
  localparam int CTRL_W = rv_pipe_pkg::CTRL_W;
  localparam int CNT_W  = 8;
  localparam logic [CTRL_W-1:0] C_LW  = 11'h00B;
  localparam logic [CTRL_W-1:0] C_ALU = 11'h001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                       input logic u2, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [CTRL_W-1:0] ctrl);
    bus.id_valid_i    = v;
    bus.id_pc_i       = pc;
    bus.id_rs1_i      = rs1;
    bus.id_rs2_i      = rs2;
    bus.id_rd_i       = rd;
    bus.id_uses_rs1_i = u1;
    bus.id_uses_rs2_i = u2;
    bus.id_reg1_i     = r1;
    bus.id_reg2_i     = r2;
    bus.id_imm_i      = imm;
    bus.id_ctrl_i     = ctrl;
  endtask

  initial begin
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, '0);
    tick();
    tick();
    chk("rst_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("rst_cnt", {24'd0, bus.bubble_cnt_o}, 32'd0);
    chk("rst_stall", {31'd0, bus.hazard_stall_o}, 32'd0);
    rst = 1'b0;

    // lw x5, 4(x2)
    drive(1'b1, 32'h100, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h4, C_LW);
    tick();
    chk("lw_valid", {31'd0, bus.ex_valid_o}, 32'd1);
    chk("lw_rd", {27'd0, bus.ex_rd_o}, 32'd5);
    chk("lw_pc", bus.ex_pc_o, 32'h100);
    chk("lw_ctrl", {21'd0, bus.ex_ctrl_o}, 32'h00B);
    chk("lw_imm", bus.ex_imm_o, 32'h4);
    chk("lw_reg1", bus.ex_reg1_o, 32'h1000);

    // add x6, x5, x7 -> load-use
    drive(1'b1, 32'h104, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0, C_ALU);
    #1;
    chk("lu_stall", {31'd0, bus.hazard_stall_o}, 32'd1);
    tick();
    chk("lu_bub_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("lu_bub_rd", {27'd0, bus.ex_rd_o}, 32'd0);
    chk("lu_bub_ctrl", {21'd0, bus.ex_ctrl_o}, 32'd0);
    chk("lu_bub_pc", bus.ex_pc_o, 32'd0);
    chk("lu_cnt1", {24'd0, bus.bubble_cnt_o}, 32'd1);
    chk("lu_stall_drop", {31'd0, bus.hazard_stall_o}, 32'd0);
    tick();
    chk("add_valid", {31'd0, bus.ex_valid_o}, 32'd1);
    chk("add_rs1", {27'd0, bus.ex_rs1_o}, 32'd5);
    chk("add_rs2", {27'd0, bus.ex_rs2_o}, 32'd7);
    chk("add_rd", {27'd0, bus.ex_rd_o}, 32'd6);
    chk("add_reg2", bus.ex_reg2_o, 32'h22);
    chk("add_pc", bus.ex_pc_o, 32'h104);

    // rs2 matches but is not used (I-type)
    drive(1'b1, 32'h108, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_LW);
    tick();
    drive(1'b1, 32'h10C, 5'd3, 5'd5, 5'd8, 1'b1, 1'b0, 32'h0, 32'h0, 32'h8, C_ALU);
    #1;
    chk("itype_stall", {31'd0, bus.hazard_stall_o}, 32'd0);
    tick();
    chk("itype_valid", {31'd0, bus.ex_valid_o}, 32'd1);
    chk("itype_rd", {27'd0, bus.ex_rd_o}, 32'd8);
    chk("itype_cnt", {24'd0, bus.bubble_cnt_o}, 32'd1);

    // lw x0 then reader of x0
    drive(1'b1, 32'h110, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_LW);
    tick();
    drive(1'b1, 32'h114, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, C_ALU);
    #1;
    chk("x0_stall", {31'd0, bus.hazard_stall_o}, 32'd0);
    tick();
    chk("x0_rd", {27'd0, bus.ex_rd_o}, 32'd9);

    // invalid decode slot becomes a bubble
    drive(1'b0, 32'h118, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h55, 32'h66, 32'h77, C_ALU);
    tick();
    chk("inv_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("inv_rd", {27'd0, bus.ex_rd_o}, 32'd0);
    chk("inv_reg1", bus.ex_reg1_o, 32'd0);

    // load-use with flush: flush wins, no count
    drive(1'b1, 32'h118, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_LW);
    tick();
    drive(1'b1, 32'h11C, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_ALU);
    bus.flush_i = 1'b1;
    #1;
    chk("fl_stall", {31'd0, bus.hazard_stall_o}, 32'd0);
    tick();
    bus.flush_i = 1'b0;
    chk("fl_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("fl_cnt", {24'd0, bus.bubble_cnt_o}, 32'd1);

    // load-use while downstream holds
    drive(1'b1, 32'h120, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_LW);
    tick();
    drive(1'b1, 32'h124, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_ALU);
    bus.stall_i = 1'b1;
    #1;
    chk("st_stall0", {31'd0, bus.hazard_stall_o}, 32'd1);
    tick();
    chk("st_hold_pc", bus.ex_pc_o, 32'h120);
    chk("st_stall1", {31'd0, bus.hazard_stall_o}, 32'd1);
    tick();
    chk("st_hold_rd", {27'd0, bus.ex_rd_o}, 32'd5);
    chk("st_cnt", {24'd0, bus.bubble_cnt_o}, 32'd1);
    bus.stall_i = 1'b0;
    #1;
    chk("st_stall2", {31'd0, bus.hazard_stall_o}, 32'd1);
    tick();
    chk("st_bub_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("st_cnt2", {24'd0, bus.bubble_cnt_o}, 32'd2);
    tick();
    chk("st_add_pc", bus.ex_pc_o, 32'h124);

    // reset during a stalled load-use
    drive(1'b1, 32'h128, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_LW);
    tick();
    drive(1'b1, 32'h12C, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_ALU);
    bus.stall_i = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("mrst_pc", bus.ex_pc_o, 32'd0);
    chk("mrst_cnt", {24'd0, bus.bubble_cnt_o}, 32'd0);
    chk("mrst_stall", {31'd0, bus.hazard_stall_o}, 32'd0);
    tick();
    rst = 1'b0;
    bus.stall_i = 1'b0;
    tick();
    chk("mrst_cap_valid", {31'd0, bus.ex_valid_o}, 32'd1);
    chk("mrst_cap_pc", bus.ex_pc_o, 32'h12C);
    chk("mrst_cap_cnt", {24'd0, bus.bubble_cnt_o}, 32'd0);

    // saturation: self-dependent load alternates load / bubble, one count per two cycles
    drive(1'b1, 32'h200, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_LW);
    for (int i = 0; i < 508; i++) tick();
    chk("sat_254", {24'd0, bus.bubble_cnt_o}, 32'd254);
    tick();
    tick();
    chk("sat_255", {24'd0, bus.bubble_cnt_o}, 32'd255);
    tick();
    chk("sat_hazard", {31'd0, bus.hazard_stall_o}, 32'd1);
    tick();
    chk("sat_bub", {31'd0, bus.ex_valid_o}, 32'd0);
    tick();
    tick();
    chk("sat_hold", {24'd0, bus.bubble_cnt_o}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
